bar_ram_writer: RTL and testbench
=================================

# bar_ram_writer

Hardware sequencer that drains 32-bit magnitude words from the spectrum FIFO, converts each to a 6-bit bar height with peak-hold decay, and writes it into the 64-entry bar RAM that feeds the display. It sits between the FIFO read port and the RAM write port, in place of the Nios II PIO polling loop. Entry 0..63 of one pass form one display frame.

## Interface
- SHIFT, default 10: right shift applied to the FIFO word before saturation.
- DECAY, default 1: per-frame decrement of the held bar height (0 disables decay).
- clk_clk  in  1  system clock; all logic on the rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- enable  in  1  level; permits new FIFO reads when high.
- frame_restart  in  1  single-cycle pulse; next write goes to address 0.
- clear_overrun  in  1  single-cycle pulse; clears overrun.
- fifo_q  in  32  FIFO read data, legacy (non-show-ahead) mode: valid the cycle after rdreq.
- fifo_rdempty  in  1  FIFO empty.
- fifo_rdfull  in  1  FIFO full.
- fifo_rdreq  out  1  FIFO read strobe, one cycle per word.
- ram_data  out  6  bar height to write.
- ram_wraddress  out  6  bar index.
- ram_wren  out  1  RAM write enable, one cycle per word.
- frame_done  out  1  one-cycle pulse coincident with the write to address 63.
- overrun  out  1  sticky; FIFO was seen full.

## Operation
- States: IDLE, REQ, WAIT, WRITE. All outputs registered.
- IDLE: if enable=1 and fifo_rdempty=0 -> REQ; else stay.
- REQ: fifo_rdreq=1 for this cycle only -> WAIT.
- WAIT: fifo_q valid. raw = fifo_q >> SHIFT (unsigned); h = 63 if raw > 63 else raw[5:0]. held = peak[addr] - DECAY, floored at 0. new = max(h, held). Register new -> WRITE.
- WRITE: ram_wren=1, ram_data=new, ram_wraddress=addr; peak[addr] <= new; frame_done=1 if addr=63. addr increments mod 64 (63 -> 0) -> IDLE.
- Internal peak array: 64 x 6-bit registers, one per bar.
- frame_restart: sets a pending flag in any state. Applied on entry to IDLE (after any in-flight WRITE has incremented addr): addr <= 0, flag cleared. Restart does not clear peak array.
- enable deasserted mid-word: current REQ/WAIT/WRITE completes; no further reads.
- overrun: set on any cycle with fifo_rdfull=1; cleared by clear_overrun. Set wins if both occur in the same cycle.
- Reset: state IDLE, addr 0, peak array all 0, pending flag 0; fifo_rdreq, ram_wren, frame_done, overrun = 0; ram_data, ram_wraddress = 0.

## Timing
- 4 clocks per word (IDLE, REQ, WAIT, WRITE); peak throughput one word per 4 cycles with FIFO continuously non-empty.
- fifo_rdreq rises at most one cycle after the IDLE cycle in which fifo_rdempty=0 and enable=1 are sampled.
- ram_wren asserts exactly 2 cycles after fifo_rdreq.
- ram_data and ram_wraddress hold their last values when ram_wren=0.
- fifo_rdempty is sampled only in IDLE, so no read is issued to an empty FIFO.
- Reset asserted in any state: next cycle outputs at reset values. An in-flight word is discarded with no RAM write.

## Test plan
- Reset, then push words 0x0000_0400, 0x0000_FC00, 0xFFFF_FFFF (SHIFT=10) -> writes addr 0,1,2 with data 1, 63, 63. Each ram_wren is 2 cycles after its rdreq and 4 cycles after the previous one.
- Fill 64 words of 0x0000_8000 -> data 32 at addr 0..63, frame_done high only with the addr 63 write. Then push word 0 -> addr 0 data 31 (decay 1). A further 30 frames of zeros -> addr 0 decays to 1, then 0, never wraps negative.
- Push 5 words, pulse frame_restart during WAIT of word 3 -> word 3 written to addr 2, word 4 written to addr 0.
- Drop enable during REQ -> that word is still written, no further rdreq while FIFO is non-empty. Raise enable -> reading resumes at the next address.
- Drive fifo_rdfull=1 for one cycle -> overrun=1 and held. Drive clear_overrun with rdfull=1 in the same cycle -> overrun stays 1. Clear with rdfull=0 -> overrun=0.
- Assert reset_reset during WAIT -> no ram_wren. All outputs are 0 the next cycle. The next word is written to addr 0 using a peak of 0.

Source files
------------

// File: rtl/bar_ram_writer.sv
// rtl/bar_ram_writer.sv - drains spectrum FIFO words into the 64-entry bar RAM
// converting each to a 6-bit bar height with per-bar peak hold and decay.
module bar_ram_writer #(
  parameter int SHIFT = 10,
  parameter int DECAY = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        enable,
  input  logic        frame_restart,
  input  logic        clear_overrun,
  input  logic [31:0] fifo_q,
  input  logic        fifo_rdempty,
  input  logic        fifo_rdfull,
  output logic        fifo_rdreq,
  output logic [5:0]  ram_data,
  output logic [5:0]  ram_wraddress,
  output logic        ram_wren,
  output logic        frame_done,
  output logic        overrun
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, WRITE} state_t;

  localparam logic [6:0] DECAY_AMT = 7'(DECAY);

  state_t      state;
  logic [5:0]  addr;
  logic        restart_pending;
  logic [5:0]  peak [64];

  logic [31:0] raw;
  logic [6:0]  peak_ext;
  logic [5:0]  height;
  logic [5:0]  held;
  logic [5:0]  next_height;

  // Height for the word on fifo_q, combined with the decayed peak of the current bar.
  always_comb begin
    raw         = fifo_q >> SHIFT;
    height      = (raw > 32'd63) ? 6'd63 : raw[5:0];
    peak_ext    = {1'b0, peak[addr]};
    held        = (peak_ext > DECAY_AMT) ? 6'(peak_ext - DECAY_AMT) : 6'd0;
    next_height = (height > held) ? height : held;
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state           <= IDLE;
      addr            <= '0;
      restart_pending <= 1'b0;
      fifo_rdreq      <= 1'b0;
      ram_wren        <= 1'b0;
      frame_done      <= 1'b0;
      overrun         <= 1'b0;
      ram_data        <= '0;
      ram_wraddress   <= '0;
      for (int i = 0; i < 64; i++) begin
        peak[i] <= '0;
      end
    end else begin
      if (fifo_rdfull) begin
        overrun <= 1'b1;
      end else if (clear_overrun) begin
        overrun <= 1'b0;
      end

      restart_pending <= restart_pending | frame_restart;

      case (state)
        IDLE: begin
          // A restart requested during a word takes effect only once its write has landed.
          if (restart_pending || frame_restart) begin
            addr            <= '0;
            restart_pending <= 1'b0;
          end
          if (enable && !fifo_rdempty) begin
            fifo_rdreq <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          fifo_rdreq <= 1'b0;
          state      <= WAIT;
        end
        WAIT: begin
          ram_wren      <= 1'b1;
          ram_data      <= next_height;
          ram_wraddress <= addr;
          frame_done    <= (addr == 6'd63);
          state         <= WRITE;
        end
        WRITE: begin
          ram_wren   <= 1'b0;
          frame_done <= 1'b0;
          peak[addr] <= ram_data;
          addr       <= addr + 6'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bar_ram_writer.sv
// tb/tb_bar_ram_writer.sv - randomized self-checking bench for bar_ram_writer
// against a per-bar peak-hold reference model.
module tb_bar_ram_writer;

  logic        clk_clk = 1'b0;
  logic        reset_reset;
  logic        enable;
  logic        frame_restart;
  logic        clear_overrun;
  logic [31:0] fifo_q;
  logic        fifo_rdempty;
  logic        fifo_rdfull;
  logic        fifo_rdreq;
  logic [5:0]  ram_data;
  logic [5:0]  ram_wraddress;
  logic        ram_wren;
  logic        frame_done;
  logic        overrun;

  int checks = 0;
  int errors = 0;

  bar_ram_writer #(.SHIFT(10), .DECAY(1)) dut (
    .clk_clk       (clk_clk),
    .reset_reset   (reset_reset),
    .enable        (enable),
    .frame_restart (frame_restart),
    .clear_overrun (clear_overrun),
    .fifo_q        (fifo_q),
    .fifo_rdempty  (fifo_rdempty),
    .fifo_rdfull   (fifo_rdfull),
    .fifo_rdreq    (fifo_rdreq),
    .ram_data      (ram_data),
    .ram_wraddress (ram_wraddress),
    .ram_wren      (ram_wren),
    .frame_done    (frame_done),
    .overrun       (overrun)
  );

  always #5 clk_clk = ~clk_clk;

  // Legacy-mode FIFO: data appears the cycle after rdreq.
  logic [31:0] fifo_mem [4096];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_rdempty = (wr_ptr == rd_ptr);

  always @(posedge clk_clk) begin
    if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
      fifo_q <= fifo_mem[rd_ptr % 4096];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Monitor: records every read strobe and RAM write with its cycle number.
  int         cyc = 0;
  int         rq_n = 0;
  int         wr_n = 0;
  int         fd_stray = 0;
  int         rq_cyc [4096];
  int         wr_cyc [4096];
  logic [5:0] wr_addr [4096];
  logic [5:0] wr_data [4096];
  logic       wr_fd [4096];

  always begin
    @(posedge clk_clk);
    #1;
    cyc = cyc + 1;
    if (fifo_rdreq === 1'b1) begin
      rq_cyc[rq_n % 4096] = cyc;
      rq_n = rq_n + 1;
    end
    if (ram_wren === 1'b1) begin
      wr_cyc[wr_n % 4096]  = cyc;
      wr_addr[wr_n % 4096] = ram_wraddress;
      wr_data[wr_n % 4096] = ram_data;
      wr_fd[wr_n % 4096]   = frame_done;
      wr_n = wr_n + 1;
    end else if (frame_done === 1'b1) begin
      fd_stray = fd_stray + 1;
    end
  end

  // Reference model: bar heights from plain arithmetic on the word value.
  int          m_peak [64];
  int          m_addr;
  logic [31:0] pend_q [$];

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_peak[i] = 0;
    m_addr = 0;
  endtask

  task automatic model_word(input logic [31:0] w, output int a, output int d);
    logic [31:0] raw;
    int h, held;
    raw  = w >> 10;
    h    = (raw > 32'd63) ? 63 : int'(raw);
    held = m_peak[m_addr] - 1;
    if (held < 0) held = 0;
    d = (h > held) ? h : held;
    a = m_addr;
    m_peak[a] = d;
    m_addr = (m_addr + 1) % 64;
  endtask

  task automatic push(input logic [31:0] w);
    fifo_mem[wr_ptr % 4096] = w;
    wr_ptr = wr_ptr + 1;
    pend_q.push_back(w);
  endtask

  task automatic wait_writes(input int target, input int budget, output bit ok);
    int n = 0;
    while (wr_n < target && n < budget) begin
      @(negedge clk_clk);
      n++;
    end
    ok = (wr_n >= target);
  endtask

  task automatic wait_reqs(input int target, input int budget, output bit ok);
    int n = 0;
    while (rq_n < target && n < budget) begin
      @(negedge clk_clk);
      n++;
    end
    ok = (rq_n >= target);
  endtask

  task automatic do_reset();
    reset_reset = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    reset_reset = 1'b1;
    enable = 1'b0;
    frame_restart = 1'b0;
    clear_overrun = 1'b0;
    fifo_rdfull = 1'b0;
    repeat (2) @(negedge clk_clk);
    checks++; if (fifo_rdreq !== 1'b0) begin errors++; $display("FAIL reset_rdreq got %b want 0", fifo_rdreq); end
    checks++; if (ram_wren !== 1'b0) begin errors++; $display("FAIL reset_wren got %b want 0", ram_wren); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got %b want 0", frame_done); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", overrun); end
    checks++; if (ram_data !== 6'd0) begin errors++; $display("FAIL reset_data got %0d want 0", ram_data); end
    checks++; if (ram_wraddress !== 6'd0) begin errors++; $display("FAIL reset_addr got %0d want 0", ram_wraddress); end
    reset_reset = 1'b0;
    model_reset();
  endtask

  task automatic test_basic();
    int w0, r0, ea, ed;
    bit ok;
    w0 = wr_n; r0 = rq_n;
    enable = 1'b1;
    push(32'h0000_0400); push(32'h0000_FC00); push(32'hFFFF_FFFF);
    wait_writes(w0 + 3, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_timeout got %0d writes want 3", wr_n - w0); end
    for (int k = 0; k < 3; k++) begin
      model_word(pend_q.pop_front(), ea, ed);
      checks++; if (wr_addr[w0+k] !== ea[5:0]) begin errors++; $display("FAIL basic_addr[%0d] got %0d want %0d", k, wr_addr[w0+k], ea); end
      checks++; if (wr_data[w0+k] !== ed[5:0]) begin errors++; $display("FAIL basic_data[%0d] got %0d want %0d", k, wr_data[w0+k], ed); end
      checks++; if (wr_cyc[w0+k] - rq_cyc[r0+k] != 2) begin errors++; $display("FAIL basic_latency[%0d] got %0d want 2", k, wr_cyc[w0+k] - rq_cyc[r0+k]); end
      if (k > 0) begin
        checks++; if (wr_cyc[w0+k] - wr_cyc[w0+k-1] != 4) begin errors++; $display("FAIL basic_spacing[%0d] got %0d want 4", k, wr_cyc[w0+k] - wr_cyc[w0+k-1]); end
      end
    end
    checks++; if (wr_data[w0+1] !== 6'd63 || wr_data[w0] !== 6'd1) begin errors++; $display("FAIL basic_const got %0d,%0d want 1,63", wr_data[w0], wr_data[w0+1]); end
  endtask

  task automatic test_frame_decay();
    int w0, ea, ed, n, fd0, last0, prev0;
    bit ok;
    do_reset();
    w0 = wr_n; fd0 = fd_stray;
    for (int i = 0; i < 64; i++) push(32'h0000_8000);
    for (int i = 0; i < 32 * 64; i++) push(32'h0);
    n = 64 + 32 * 64;
    wait_writes(w0 + n, n * 4 + 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL frame_timeout got %0d writes want %0d", wr_n - w0, n); end
    last0 = -1; prev0 = -1;
    for (int k = 0; k < n; k++) begin
      model_word(pend_q.pop_front(), ea, ed);
      checks++; if (wr_addr[w0+k] !== ea[5:0] || wr_data[w0+k] !== ed[5:0]) begin errors++; $display("FAIL frame_write[%0d] got a%0d d%0d want a%0d d%0d", k, wr_addr[w0+k], wr_data[w0+k], ea, ed); end
      checks++; if (wr_fd[w0+k] !== (ea == 63)) begin errors++; $display("FAIL frame_done[%0d] got %b want %b", k, wr_fd[w0+k], ea == 63); end
      if (ea == 0) begin prev0 = last0; last0 = int'(wr_data[w0+k]); end
    end
    checks++; if (wr_data[w0+64] !== 6'd31) begin errors++; $display("FAIL frame_decay_first got %0d want 31", wr_data[w0+64]); end
    checks++; if (prev0 != 1 || last0 != 0) begin errors++; $display("FAIL frame_decay_floor got %0d,%0d want 1,0", prev0, last0); end
    checks++; if (fd_stray != fd0) begin errors++; $display("FAIL frame_done_stray got %0d want %0d", fd_stray, fd0); end
  endtask

  task automatic test_random();
    int w0, ea, ed, n;
    bit ok;
    w0 = wr_n; n = 150;
    for (int i = 0; i < n; i++) begin
      push($urandom >> $urandom_range(0, 31));
      repeat ($urandom_range(0, 6)) @(negedge clk_clk);
    end
    wait_writes(w0 + n, n * 4 + 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL random_timeout got %0d writes want %0d", wr_n - w0, n); end
    for (int k = 0; k < n; k++) begin
      model_word(pend_q.pop_front(), ea, ed);
      checks++; if (wr_addr[w0+k] !== ea[5:0] || wr_data[w0+k] !== ed[5:0]) begin errors++; $display("FAIL random_write[%0d] got a%0d d%0d want a%0d d%0d", k, wr_addr[w0+k], wr_data[w0+k], ea, ed); end
      checks++; if (wr_fd[w0+k] !== (ea == 63)) begin errors++; $display("FAIL random_frame_done[%0d] got %b want %b", k, wr_fd[w0+k], ea == 63); end
    end
  endtask

  task automatic test_restart();
    int w0, r0, ea, ed;
    bit ok;
    do_reset();
    w0 = wr_n; r0 = rq_n;
    for (int i = 0; i < 5; i++) push($urandom >> $urandom_range(4, 24));
    wait_reqs(r0 + 3, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_req_timeout got %0d reqs want 3", rq_n - r0); end
    @(negedge clk_clk);
    frame_restart = 1'b1;
    @(negedge clk_clk);
    frame_restart = 1'b0;
    wait_writes(w0 + 5, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL restart_timeout got %0d writes want 5", wr_n - w0); end
    for (int k = 0; k < 5; k++) begin
      if (k == 3) m_addr = 0;
      model_word(pend_q.pop_front(), ea, ed);
      checks++; if (wr_addr[w0+k] !== ea[5:0] || wr_data[w0+k] !== ed[5:0]) begin errors++; $display("FAIL restart_write[%0d] got a%0d d%0d want a%0d d%0d", k, wr_addr[w0+k], wr_data[w0+k], ea, ed); end
    end
    checks++; if (wr_addr[w0+2] !== 6'd2 || wr_addr[w0+3] !== 6'd0) begin errors++; $display("FAIL restart_const got %0d,%0d want 2,0", wr_addr[w0+2], wr_addr[w0+3]); end
  endtask

  task automatic test_enable();
    int w0, r0, ea, ed;
    bit ok;
    w0 = wr_n; r0 = rq_n;
    for (int i = 0; i < 4; i++) push($urandom >> $urandom_range(4, 24));
    wait_reqs(r0 + 1, 100, ok);
    enable = 1'b0;
    checks++; if (!ok) begin errors++; $display("FAIL enable_req_timeout got %0d reqs want 1", rq_n - r0); end
    repeat (20) @(negedge clk_clk);
    checks++; if (wr_n - w0 != 1) begin errors++; $display("FAIL enable_inflight got %0d writes want 1", wr_n - w0); end
    checks++; if (rq_n - r0 != 1) begin errors++; $display("FAIL enable_stopped got %0d reqs want 1", rq_n - r0); end
    enable = 1'b1;
    wait_writes(w0 + 4, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL enable_timeout got %0d writes want 4", wr_n - w0); end
    for (int k = 0; k < 4; k++) begin
      model_word(pend_q.pop_front(), ea, ed);
      checks++; if (wr_addr[w0+k] !== ea[5:0] || wr_data[w0+k] !== ed[5:0]) begin errors++; $display("FAIL enable_write[%0d] got a%0d d%0d want a%0d d%0d", k, wr_addr[w0+k], wr_data[w0+k], ea, ed); end
    end
  endtask

  task automatic test_overrun();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_initial got %b want 0", overrun); end
    fifo_rdfull = 1'b1;
    @(negedge clk_clk);
    fifo_rdfull = 1'b0;
    repeat (3) @(negedge clk_clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky got %b want 1", overrun); end
    fifo_rdfull = 1'b1; clear_overrun = 1'b1;
    @(negedge clk_clk);
    fifo_rdfull = 1'b0; clear_overrun = 1'b0;
    @(negedge clk_clk);
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set_wins got %b want 1", overrun); end
    clear_overrun = 1'b1;
    @(negedge clk_clk);
    clear_overrun = 1'b0;
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b want 0", overrun); end
  endtask

  task automatic test_reset_midword();
    int w0, r0, ea, ed;
    bit ok;
    frame_restart = 1'b1;
    @(negedge clk_clk);
    frame_restart = 1'b0;
    m_addr = 0;
    w0 = wr_n;
    push(32'hFFFF_FFFF);
    wait_writes(w0 + 1, 100, ok);
    model_word(pend_q.pop_front(), ea, ed);
    checks++; if (!ok || wr_addr[w0] !== 6'd0 || wr_data[w0] !== 6'd63) begin errors++; $display("FAIL midreset_prime got a%0d d%0d want a0 d63", wr_addr[w0], wr_data[w0]); end
    w0 = wr_n; r0 = rq_n;
    push(32'h0000_0400);
    wait_reqs(r0 + 1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL midreset_req_timeout got %0d reqs want 1", rq_n - r0); end
    @(negedge clk_clk);
    reset_reset = 1'b1;
    @(negedge clk_clk);
    reset_reset = 1'b0;
    checks++; if ({fifo_rdreq, ram_wren, frame_done, overrun} !== 4'b0) begin errors++; $display("FAIL midreset_ctrl got %b want 0000", {fifo_rdreq, ram_wren, frame_done, overrun}); end
    checks++; if (ram_data !== 6'd0 || ram_wraddress !== 6'd0) begin errors++; $display("FAIL midreset_bus got d%0d a%0d want 0 0", ram_data, ram_wraddress); end
    void'(pend_q.pop_front());
    model_reset();
    repeat (8) @(negedge clk_clk);
    checks++; if (wr_n != w0) begin errors++; $display("FAIL midreset_discard got %0d writes want 0", wr_n - w0); end
    push(32'h0);
    wait_writes(w0 + 1, 100, ok);
    model_word(pend_q.pop_front(), ea, ed);
    checks++; if (!ok || wr_addr[w0] !== ea[5:0] || wr_data[w0] !== ed[5:0]) begin errors++; $display("FAIL midreset_after got a%0d d%0d want a%0d d%0d", wr_addr[w0], wr_data[w0], ea, ed); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_frame_decay();
    test_random();
    test_restart();
    test_enable();
    test_overrun();
    test_reset_midword();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
